apb_timer_master: RTL and testbench

//   APB3 initiator that drives the 8-bit timer's register slave (control, count, compare regs).

---
 rtl/apb_timer_pkg.sv | 15 +
 rtl/apb_timer_master.sv | 109 ++++++++++
 tb/tb_apb_timer_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the timer's APB master and slave decoder: FSM encodings
// and the timer register address map.
package apb_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TMR_CTRL_ADDR  = 8'h00;
  localparam logic [7:0] TMR_COUNT_ADDR = 8'h01;
  localparam logic [7:0] TMR_CMP_ADDR   = 8'h02;

endpackage

// File: rtl/apb_timer_master.sv
// APB3 initiator for the timer register slave: one command in, one SETUP/ACCESS transfer,
// one response out. Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC wait cycles.
module apb_timer_master
  import apb_timer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT_CYC < 1) begin : g_timeout_range
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Counts completed ACCESS wait cycles; abort fires on the TIMEOUT_CYC-th one.
  logic [CNT_W-1:0] acc_cnt;
`endif

  // Gated by reset so the host never sees a ready while the block is held in reset.
  assign cmd_ready = (state == ST_IDLE) && PRESETn;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      acc_cnt   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= ST_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
            acc_cnt <= '0;
`endif
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            state     <= ST_IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (acc_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_IDLE;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
`endif
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer_master.sv
// Scoreboard bench for apb_timer_master: randomized commands against a register-file
// reference, a wait-state/error APB slave model, and a decoupled response/bus monitor.
module tb_apb_timer_master;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         waits;
    logic       err;
  } plan_t;

  typedef struct {
    logic [7:0] rd;
    logic       er;
  } exp_t;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b0;
  logic       PSLVERR = 1'b0;

  apb_timer_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_pass = 0;
  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    rsp_cyc_q[$];
  logic [7:0] ref_mem[256];
  logic [7:0] smem[256];
  bit chk_lat = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- slave model: wait states, error, register storage ----------------
  plan_t cur;
  int    wl;
  always @(negedge PCLK) begin
    if (!PSEL) begin
      PREADY  = 1'b0;
      PSLVERR = 1'($urandom);
      PRDATA  = 8'($urandom);
    end else if (!PENABLE) begin
      if (plan_q.size() == 0) begin
        chk("unplanned_transfer", 1, 0);
        cur = '{1'b0, 8'h00, 8'h00, 0, 1'b0};
      end else begin
        cur = plan_q.pop_front();
        chk("setup_addr", PADDR, cur.a);
        chk("setup_dir", PWRITE, cur.w);
        if (cur.w) chk("setup_wdata", PWDATA, cur.d);
      end
      wl      = cur.waits;
      PREADY  = 1'b0;
      PSLVERR = 1'($urandom);
      PRDATA  = 8'($urandom);
    end else if (wl == 0) begin
      PREADY  = 1'b1;
      PSLVERR = cur.err;
      PRDATA  = cur.w ? 8'($urandom) : smem[cur.a];
      if (cur.w && !cur.err) smem[cur.a] = cur.d;
    end else begin
      wl--;
      PREADY  = 1'b0;
      PSLVERR = 1'($urandom);
      PRDATA  = 8'($urandom);
    end
  end

  // ---------------- monitor: responses and bus-protocol checks ----------------
  exp_t       mon_e;
  int         cyc = 0;
  int         pen_run = 0;
  int         last_run = 0;
  bit         prev_done = 1'b0;
  bit         prev_setup = 1'b0;
  logic [7:0] last_rd = '0;
  logic       last_er = 1'b0;
  logic [16:0] lat_bus = '0;
  always @(negedge PCLK) begin
    #2;
    cyc++;
    if (!PRESETn) begin
      last_rd = '0;
      last_er = 1'b0;
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rd);
        chk("rsp_err", rsp_err, mon_e.er);
        last_rd = mon_e.rd;
        last_er = mon_e.er;
      end
      chk("ready_in_rsp_cycle", cmd_ready, 1);
      rsp_cyc_q.push_back(cyc);
    end else if (PRESETn) begin
      chk("rsp_hold", {rsp_err, rsp_rdata}, {last_er, last_rd});
    end
    if (PRESETn) begin
      if (chk_lat) chk("rsp_latency", rsp_valid, prev_done);
      chk("ready_vs_psel", cmd_ready, !PSEL);
      if (PENABLE) chk("penable_needs_psel", PSEL, 1);
      if (prev_setup) chk("setup_one_cycle", {PSEL, PENABLE}, 2'b11);
      if (PSEL && !PENABLE) lat_bus = {PWRITE, PADDR, PWDATA};
      if (PSEL && PENABLE) chk("bus_stable", {PWRITE, PADDR, PWDATA}, lat_bus);
    end
    if (PENABLE) pen_run++;
    else if (pen_run != 0) begin
      last_run = pen_run;
      pen_run = 0;
    end
    prev_done  = PSEL && PENABLE && PREADY;
    prev_setup = PSEL && !PENABLE;
  end

  // ---------------- driver with reference model ----------------
  // mode: 0 = no response expected, 1 = normal completion, 2 = timeout abort
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int waits, input logic err, input int mode);
    exp_t e;
    plan_t p;
    int n;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge PCLK);
    p = '{w, a, d, waits, err};
    plan_q.push_back(p);
    if (mode == 2) e = '{8'h00, 1'b1};
    else if (w) begin
      e = '{8'h00, err};
      if (!err) ref_mem[a] = d;
    end else e = '{ref_mem[a], err};
    if (mode != 0) exp_q.push_back(e);
    #1;
  endtask

  task automatic drop();
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_wait_timeout", exp_q.size(), 0);
      exp_q.delete();
      plan_q.delete();
    end
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i * 7 + 3);
      smem[i]    = 8'(i * 7 + 3);
    end
    repeat (2) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus", {PWRITE, PADDR, PWDATA}, 0);
    chk("rst_rsp", {rsp_err, rsp_rdata}, 0);
    #3 PRESETn = 1'b1;
    #1 chk("ready_after_rst", cmd_ready, 1);

    // write A5 to control with zero wait states
    send(1'b1, 8'h00, 8'hA5, 0, 1'b0, 1);
    drop();
    wait_idle();
    chk("t1_access_len", last_run, 1);

    // read compare register after three wait states
    send(1'b1, 8'h02, 8'h3C, 0, 1'b0, 1);
    send(1'b0, 8'h02, 8'h00, 3, 1'b0, 1);
    drop();
    wait_idle();
    chk("t2_access_len", last_run, 4);

    // back-to-back stream including an erroring read
    rsp_cyc_q.delete();
    send(1'b1, 8'h01, 8'h77, 0, 1'b0, 1);
    send(1'b0, 8'h02, 8'h00, 0, 1'b1, 1);
    send(1'b0, 8'h01, 8'h00, 0, 1'b0, 1);
    drop();
    wait_idle();
    chk("b2b_count", rsp_cyc_q.size(), 3);
    if (rsp_cyc_q.size() == 3) begin
      chk("b2b_gap1", rsp_cyc_q[1] - rsp_cyc_q[0], 3);
      chk("b2b_gap2", rsp_cyc_q[2] - rsp_cyc_q[1], 3);
    end

    // reset in the middle of ACCESS
    send(1'b0, 8'h01, 8'h00, 50, 1'b0, 0);
    drop();
    for (int n = 0; n < 20 && !PENABLE; n++) @(negedge PCLK);
    chk("t4_reached_access", PENABLE, 1);
    repeat (2) @(negedge PCLK);
    #3 PRESETn = 1'b0;
    #1 chk("t4_async_psel", PSEL, 0);
    chk("t4_async_penable", PENABLE, 0);
    repeat (2) @(negedge PCLK);
    chk("t4_no_rsp", rsp_valid, 0);
    #3 PRESETn = 1'b1;
    plan_q.delete();
    send(1'b0, 8'h01, 8'h00, 1, 1'b0, 1);
    drop();
    wait_idle();

`ifdef APB_MASTER_TIMEOUT_EN
    chk_lat = 1'b0;
    send(1'b0, 8'h03, 8'h00, 100, 1'b0, 2);
    drop();
    wait_idle();
    chk("to_abort_len", last_run, 16);
    chk_lat = 1'b1;
    send(1'b0, 8'h03, 8'h00, 15, 1'b0, 1);
    drop();
    wait_idle();
    chk("to_last_cycle_len", last_run, 16);
`endif

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      logic w, e;
      logic [7:0] a, d;
      int ws, gap;
      w   = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 7));
      d   = 8'($urandom);
      ws  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      e   = ($urandom_range(0, 7) == 0);
      send(w, a, d, ws, e, 1);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        drop();
        repeat (gap) @(negedge PCLK);
      end
    end
    drop();
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
